// File: rtl/count_match_ctrl.sv
// Run controller for the counter/comparator datapath.
// It latches a compare-select vector and a cycle budget on START, then strobes
// the datapath count enable until the datapath reports a match, the budget is
// used up, or the master aborts. One end-of-run pulse carries the result.
//
// Handshake: START is a level request that is sampled only in IDLE. Holding it
// high while BUSY has no effect, and requests are never queued. ABORT is
// sampled only in SETUP and RUN. DONE is a single-cycle pulse. HIT/TMO/ABRT and
// CYC_CNT stay valid from DONE until the next accepted START.
module count_match_ctrl #(
  parameter int CW = 17,
  parameter int MW = 16
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic [CW-1:0] CFG_C,
  input  logic [MW-1:0] MAX_CYC,
  input  logic          DUT_Z,
  output logic          DUT_P0,
  output logic [CW-1:0] DUT_C,
  output logic          BUSY,
  output logic          DONE,
  output logic          HIT,
  output logic          TMO,
  output logic          ABRT,
  output logic [MW-1:0] CYC_CNT,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [MW-1:0] ONE = {{(MW-1){1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [MW-1:0] max_q, max_d;
  logic [CW-1:0] c_d;
  logic          hit_d, tmo_d, abrt_d;
  logic [MW-1:0] cnt_d;

  assign dbg_state = state_q;

  // Next-state and next-result decode; outputs are registered from these.
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    c_d     = DUT_C;
    hit_d   = HIT;
    tmo_d   = TMO;
    abrt_d  = ABRT;
    cnt_d   = CYC_CNT;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_SETUP;
          c_d     = CFG_C;
          max_d   = MAX_CYC;
          hit_d   = 1'b0;
          tmo_d   = 1'b0;
          abrt_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        // Count enable is low here, so Z reflects the new compare-select only.
        if (DUT_Z) begin
          state_d = S_DONE;
          hit_d   = 1'b1;
          cnt_d   = '0;
        end else if (max_q == '0) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end else if (ABORT) begin
          state_d = S_DONE;
          abrt_d  = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Budget is non-zero here, so max_q - 1 cannot underflow.
        if (DUT_Z) begin
          state_d = S_DONE;
          hit_d   = 1'b1;
        end else if (CYC_CNT == max_q - ONE) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
          cnt_d   = CYC_CNT + ONE;
        end else if (ABORT) begin
          state_d = S_DONE;
          abrt_d  = 1'b1;
        end else begin
          cnt_d   = CYC_CNT + ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; P0 is deliberately not gated by Z.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      max_q   <= '0;
      DUT_C   <= '0;
      DUT_P0  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      HIT     <= 1'b0;
      TMO     <= 1'b0;
      ABRT    <= 1'b0;
      CYC_CNT <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      DUT_C   <= c_d;
      DUT_P0  <= (state_d == S_RUN);
      BUSY    <= (state_d != S_IDLE);
      DONE    <= (state_d == S_DONE);
      HIT     <= hit_d;
      TMO     <= tmo_d;
      ABRT    <= abrt_d;
      CYC_CNT <= cnt_d;
    end
  end

endmodule
